// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment display driver.
package ssd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  localparam int unsigned NUM_BITS = 13;
  localparam int unsigned BCD_BITS = 16;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int unsigned DIG_UNITS = 0;
  localparam int unsigned DIG_TENS  = 1;
  localparam int unsigned DIG_HUNDS = 2;
  localparam int unsigned DIG_THOUS = 3;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/ssd_driver_if.sv
// Value-in / display-out bundle between the CPU debug port and the display driver.
interface ssd_driver_if;
  logic [12:0] num;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        busy;

  modport master (output num, input anode, input seg, input busy);
  modport slave  (input num, output anode, output seg, output busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 13-bit binary to four BCD digits, one bit per cycle.
module bin2bcd_seq
  import ssd_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] num_i,
  output logic [BCD_BITS-1:0] bcd_o,
  output logic                done_o,
  output logic                busy_o
);

  state_t                state_q;
  logic [NUM_BITS-1:0]   bin_q;
  logic [NUM_BITS-1:0]   cap_q;
  logic [NUM_BITS-1:0]   last_q;
  logic [BCD_BITS-1:0]   bcd_q;
  logic [BCD_BITS-1:0]   bcd_d;
  logic [BCD_BITS+NUM_BITS-1:0] shift_d;
  logic [3:0]            iter_q;
  logic                  busy_q;
  logic                  done_q;

  // Add-3 correction on every nibble >= 5, then shift the combined register left
  always_comb begin
    bcd_d = bcd_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shift_d = {bcd_d, bin_q} << 1;
  end

  // Capture / convert / load sequencer with registered busy and done
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      cap_q   <= '0;
      last_q  <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (num_i != last_q) begin
            bin_q   <= num_i;
            cap_q   <= num_i;
            bcd_q   <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_q  <= shift_d[BCD_BITS+NUM_BITS-1:NUM_BITS];
          bin_q  <= shift_d[NUM_BITS-1:0];
          iter_q <= iter_q + 4'd1;
          if (iter_q == 4'(NUM_BITS - 1)) begin
            done_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          last_q  <= cap_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = done_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/ssd_driver.sv
// Four-digit multiplexed common-anode display driver with leading-zero blanking.
module ssd_driver
  import ssd_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 18,
  parameter bit          BLANK_LZ     = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  ssd_driver_if.slave  bus
);

  logic [REFRESH_BITS-1:0] cnt_q;
  logic [BCD_BITS-1:0]     digit_q;
  logic [3:0]              anode_q;
  logic [6:0]              seg_q;
  logic [BCD_BITS-1:0]     bcd;
  logic                    done;
  logic                    busy;
  logic [1:0]              sel;
  logic [3:0]              blank_d;
  logic [3:0]              nib_d;
  logic [3:0]              anode_d;
  logic [6:0]              seg_d;

  bin2bcd_seq u_conv (
    .clk    (clk),
    .rst    (rst),
    .num_i  (bus.num),
    .bcd_o  (bcd),
    .done_o (done),
    .busy_o (busy)
  );

  assign sel = cnt_q[REFRESH_BITS-1 -: 2];

  // Select the active digit, apply leading-zero blanking and decode segments
  always_comb begin
    blank_d            = '0;
    blank_d[DIG_THOUS] = BLANK_LZ && (digit_q[4*DIG_THOUS +: 4] == 4'd0);
    blank_d[DIG_HUNDS] = blank_d[DIG_THOUS] && (digit_q[4*DIG_HUNDS +: 4] == 4'd0);
    blank_d[DIG_TENS]  = blank_d[DIG_HUNDS] && (digit_q[4*DIG_TENS +: 4] == 4'd0);
    nib_d              = digit_q[{sel, 2'b00} +: 4];
    seg_d              = blank_d[sel] ? SEG_BLANK : seg_decode(nib_d);
    anode_d            = ~(4'b0001 << sel);
  end

  // Scan counter, digit latch on conversion done, registered display outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      digit_q <= '0;
      anode_q <= '1;
      seg_q   <= SEG_BLANK;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
      if (done) digit_q <= bcd;
      anode_q <= anode_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.anode = anode_q;
  assign bus.seg   = seg_q;
  assign bus.busy  = busy;

endmodule

// File: tb/tb_ssd_driver.sv
// Self-checking bench for ssd_driver against a decimal reference model.
module tb_ssd_driver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  ssd_driver_if bus ();
  ssd_driver_if bus_nb ();

  assign bus_nb.num = bus.num;

  ssd_driver #(.REFRESH_BITS(4), .BLANK_LZ(1'b1)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  ssd_driver #(.REFRESH_BITS(4), .BLANK_LZ(1'b0)) dut_nb (
    .clk (clk), .rst (rst), .bus (bus_nb)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] ref_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] ref_seg(input int v, input int k, input bit blz);
    int d;
    if (blz && k > 0 && v < pow10(k)) return 7'b1111111;
    d = (v / pow10(k)) % 10;
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  task automatic wait_conv(output int hi, output bit ok);
    int n;
    hi = 0; ok = 1'b0; n = 0;
    while (bus.busy !== 1'b1 && n < 20) begin tick(); n++; end
    if (bus.busy === 1'b1) begin
      n = 0;
      while (bus.busy === 1'b1 && n < 40) begin hi++; tick(); n++; end
      ok = (bus.busy === 1'b0);
    end
  endtask

  task automatic check_scan(input string name, input int v, input bit nb);
    logic [3:0] an;
    logic [6:0] sg, exp;
    logic [3:0] seen;
    int k;
    seen = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      an = nb ? bus_nb.anode : bus.anode;
      sg = nb ? bus_nb.seg : bus.seg;
      k = -1;
      for (int j = 0; j < 4; j++) if (an === ~(4'b0001 << j)) k = j;
      n_checks++;
      if (k < 0) begin
        n_fail++;
        $display("FAIL %s anode: got %b, want one-hot-low", name, an);
      end else begin
        seen[k] = 1'b1;
        exp = ref_seg(v, k, !nb);
        n_checks++;
        if (sg !== exp) begin
          n_fail++;
          $display("FAIL %s seg digit %0d: got %b, want %b", name, k, sg, exp);
        end
      end
    end
    n_checks++;
    if (seen !== 4'hf) begin
      n_fail++;
      $display("FAIL %s slots seen: got %b, want 1111", name, seen);
    end
  endtask

  task automatic convert_and_check(input string name, input int v);
    int hi; bit ok;
    bus.num = 13'(v);
    wait_conv(hi, ok);
    n_checks++;
    if (!ok || hi != 14) begin
      n_fail++;
      $display("FAIL %s busy: got %0d cycles (ok=%0d), want 14", name, hi, ok);
    end
    n_checks++;
    if (dut.digit_q !== ref_bcd(v)) begin
      n_fail++;
      $display("FAIL %s bcd: got %h, want %h", name, dut.digit_q, ref_bcd(v));
    end
  endtask

  task automatic test_reset();
    bit busy_seen;
    rst = 1'b0;
    bus.num = '0;
    repeat (3) tick();
    n_checks++;
    if (bus.anode !== 4'b1111) begin
      n_fail++; $display("FAIL reset anode: got %b, want 1111", bus.anode);
    end
    n_checks++;
    if (bus.seg !== 7'b1111111) begin
      n_fail++; $display("FAIL reset seg: got %b, want 1111111", bus.seg);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset busy: got %b, want 0", bus.busy);
    end
    rst = 1'b1;
    busy_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.busy !== 1'b0) busy_seen = 1'b1;
    end
    n_checks++;
    if (busy_seen) begin
      n_fail++; $display("FAIL idle busy: got 1 after release, want 0");
    end
    check_scan("zero", 0, 1'b0);
  endtask

  task automatic test_max();
    convert_and_check("max", 8191);
    check_scan("max_scan", 8191, 1'b0);
  endtask

  task automatic test_blanking();
    convert_and_check("lz245", 245);
    check_scan("lz245_blank", 245, 1'b0);
    check_scan("lz245_noblank", 245, 1'b1);
  endtask

  task automatic test_back_to_back();
    int hi, n;
    bit ok;
    bus.num = 13'd100;
    n = 0;
    while (bus.busy !== 1'b1 && n < 20) begin tick(); n++; end
    repeat (5) tick();
    bus.num = 13'd7;
    hi = 6;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin tick(); n++; if (bus.busy === 1'b1) hi++; end
    n_checks++;
    if (hi != 14) begin
      n_fail++; $display("FAIL b2b first busy: got %0d cycles, want 14", hi);
    end
    n_checks++;
    if (dut.digit_q !== ref_bcd(100)) begin
      n_fail++; $display("FAIL b2b first bcd: got %h, want %h", dut.digit_q, ref_bcd(100));
    end
    tick();
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b gap: busy got %b after 1 idle cycle, want 1", bus.busy);
    end
    wait_conv(hi, ok);
    n_checks++;
    if (!ok || hi != 14) begin
      n_fail++; $display("FAIL b2b second busy: got %0d cycles (ok=%0d), want 14", hi, ok);
    end
    n_checks++;
    if (dut.digit_q !== ref_bcd(7)) begin
      n_fail++; $display("FAIL b2b second bcd: got %h, want %h", dut.digit_q, ref_bcd(7));
    end
    check_scan("b2b_scan", 7, 1'b0);
  endtask

  task automatic test_reset_mid();
    int n;
    bus.num = 13'd4321;
    n = 0;
    while (bus.busy !== 1'b1 && n < 20) begin tick(); n++; end
    repeat (7) tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset busy: got %b, want 0", bus.busy);
    end
    n_checks++;
    if (dut.digit_q !== 16'h0000) begin
      n_fail++; $display("FAIL midreset digits: got %h, want 0000", dut.digit_q);
    end
    n_checks++;
    if (bus.anode !== 4'b1111) begin
      n_fail++; $display("FAIL midreset anode: got %b, want 1111", bus.anode);
    end
    rst = 1'b1;
    convert_and_check("midreset_restart", 4321);
    check_scan("midreset_scan", 4321, 1'b0);
  endtask

  task automatic test_sweep();
    int vals[$];
    int prev;
    for (int v = 0; v < 64; v++) vals.push_back(v);
    for (int v = 8128; v < 8192; v++) vals.push_back(v);
    vals.push_back(999);  vals.push_back(1000); vals.push_back(99);
    vals.push_back(100);  vals.push_back(4095); vals.push_back(4096);
    vals.push_back(8000); vals.push_back(7999);
    for (int i = 0; i < 1200; i++) vals.push_back(int'($urandom_range(0, 8191)));
    prev = 4321;
    foreach (vals[i]) begin
      if (vals[i] != prev) begin
        convert_and_check("sweep", vals[i]);
        prev = vals[i];
      end
    end
  endtask

  initial begin
    bus.num = '0;
    test_reset();
    test_max();
    test_blanking();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
